wb_ram_slave: RTL and testbench
===============================

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the memory depth of 2**ADDR_WIDTH 32-bit words.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, giving wait cycles inserted before ack; legal range 0..15.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The port clk_i SHALL be an input of 1 bit: the clock; all state changes on its rising edge.
REQ-005 The port rst_n_i SHALL be an input of 1 bit: the asynchronous, active-low reset.
REQ-006 The port wbs_dat_i SHALL be an input of 32 bits: write data from the master.
REQ-007 The port wbs_dat_o SHALL be an output of 32 bits: read data to the master.
REQ-008 The port wbs_adr_i SHALL be an input of 32 bits: byte address; word index = wbs_adr_i[ADDR_WIDTH+1:2].
REQ-009 The port wbs_sel_i SHALL be an input of 2 bits: halfword lane select; bit 1 selects [31:16], bit 0 selects [15:0].
REQ-010 The port wbs_we_i SHALL be an input of 1 bit: 1 means write, 0 means read.
REQ-011 The port wbs_cyc_i SHALL be an input of 1 bit: bus cycle in progress.
REQ-012 The port wbs_stb_i SHALL be an input of 1 bit: strobe, valid transfer request.
REQ-013 The port wbs_ack_o SHALL be an output of 1 bit: transfer acknowledge, one cycle per accepted transfer.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, WAIT and ACK.
REQ-015 The block SHALL treat a request as present when wbs_cyc_i=1 and wbs_stb_i=1 on a rising edge; wbs_stb_i without wbs_cyc_i SHALL be ignored.
REQ-016 IDLE with a request present: WAIT_STATES=0 -> ACK; otherwise -> WAIT with wait counter loaded to WAIT_STATES.
REQ-017 WAIT: the counter SHALL decrement each cycle; when it equals 1 and the request is still present, the next state SHALL be ACK.
REQ-018 WAIT with cyc or stb deasserted (abort) SHALL go to IDLE, produce no ack and perform no write.
REQ-019 ACK SHALL always go to IDLE next cycle; wbs_ack_o SHALL be 1 only while in ACK, for exactly one cycle.
REQ-020 Latency: with the request first present in cycle 0, wbs_ack_o SHALL be high in cycle 1+WAIT_STATES; throughput SHALL be one transfer per WAIT_STATES+2 cycles.
REQ-021 Write commit SHALL occur at the edge that enters ACK, using inputs sampled at that edge; only lanes with the wbs_sel_i bit set are updated.
REQ-022 A write with wbs_sel_i=2'b00 SHALL complete with ack and leave memory unchanged.
REQ-023 For a read, wbs_dat_o SHALL be loaded at the edge that enters ACK with the addressed word and SHALL be valid throughout the ACK cycle.
REQ-024 wbs_dat_o SHALL hold its last value at all other times, including after writes.
REQ-025 Address bits above ADDR_WIDTH+1 and bits [1:0] SHALL be ignored, so accesses alias across the memory.
REQ-026 A master holding cyc and stb high after ack SHALL be treated as a new request sampled in the cycle after ACK (IDLE), starting a new transfer.

Reset
REQ-027 While rst_n_i=0 the block SHALL force state IDLE, wait counter 0, wbs_ack_o=0 and wbs_dat_o=32'h0 immediately, without waiting for a clock edge.
REQ-028 Memory contents SHALL NOT be reset and are undefined until written.
REQ-029 Reset asserted in WAIT or ACK SHALL abort the transfer with no ack; an uncommitted write SHALL not occur.
REQ-030 After reset release the first request SHALL be sampled on the first rising edge with rst_n_i=1.

Verification
REQ-031 WAIT_STATES=1; write adr 0x10, data 0xDEADBEEF, sel 2'b11 -> ack in cycle 2; then a read of 0x10 -> ack in cycle 2 with wbs_dat_o=0xDEADBEEF.
REQ-032 Write 0x11112222 with sel 2'b11, then 0xAAAABBBB with sel 2'b10 to the same word -> read returns 0xAAAA2222.
REQ-033 WAIT_STATES=3; drop stb in cycle 2 of a write of 0x12345678 -> no ack, and a later read returns the prior value.
REQ-034 WAIT_STATES=0; hold cyc and stb high for 3 reads -> ack in cycles 1, 3 and 5, each a single cycle.
REQ-035 ADDR_WIDTH=8; write 0x0000CAFE to adr 0x000 -> read at adr 0x400 returns 0x0000CAFE (alias).
REQ-036 Assert rst_n_i low mid-WAIT -> wbs_ack_o=0 and wbs_dat_o=0 immediately, with no ack after release.

Source files
------------

// File: rtl/wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_slave
// Description : Wishbone classic slave in front of a 2**ADDR_WIDTH x 32-bit
//               RAM with halfword lane writes and a programmable number of
//               wait states (0..15) before the single-cycle acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic [31:0] wbs_adr_i,
    input  logic [1:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic        wbs_ack_o
);

    localparam int         c_DEPTH = 2 ** ADDR_WIDTH;
    // Wait count is held in 4 bits; legal WAIT_STATES values are 0..15.
    localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_ack;
    logic [31:0]             r_dat;
    logic [31:0]             r_mem [c_DEPTH];

    logic                    w_req;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_enter_ack;
    logic                    w_commit;
    logic                    w_unused_adr;

    // A transfer request needs both cycle and strobe; strobe alone is ignored.
    assign w_req = wbs_cyc_i & wbs_stb_i;

    // Word index; the byte offset and the address bits above the RAM alias.
    assign w_idx        = wbs_adr_i[ADDR_WIDTH+1:2];
    assign w_unused_adr = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};

    // The edge that enters ACK is where the write commits and read data loads.
    assign w_enter_ack = w_req &
                         (((r_state == IDLE) && (c_WAIT == 4'd0)) ||
                          ((r_state == WAIT) && (r_cnt == 4'd1)));

    // Never let a write slip through while reset is held.
    assign w_commit = rst_n_i & w_enter_ack & wbs_we_i;

    // Transfer sequencing, wait counting and the registered bus outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_dat   <= 32'h0;
        end else begin
            r_ack <= w_enter_ack;
            if (w_enter_ack && !wbs_we_i) begin
                r_dat <= r_mem[w_idx];
            end
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (c_WAIT == 4'd0) begin
                            r_state <= ACK;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!w_req) begin
                        // Master withdrew the request: abandon silently.
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= ACK;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // RAM write port with per-halfword lane enables; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            if (wbs_sel_i[1]) begin
                r_mem[w_idx][31:16] <= wbs_dat_i[31:16];
            end
            if (wbs_sel_i[0]) begin
                r_mem[w_idx][15:0] <= wbs_dat_i[15:0];
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ram_slave
// Description : Scoreboard bench for wb_ram_slave. Three instances with
//               WAIT_STATES = 1, 0 and 3 share clock and reset; a driver
//               issues directed and random transfers and queues the expected
//               acknowledges, a negedge monitor checks them independently.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ram_slave;

    typedef struct {
        int          id;
        int          ack_cyc;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] dat_i [3];
    logic [31:0] dat_o [3];
    logic [31:0] adr_i [3];
    logic [1:0]  sel_i [3];
    logic        we_i  [3];
    logic        cyc_i [3];
    logic        stb_i [3];
    logic        ack_o [3];

    int          cyc_n;
    int          n_checks;
    int          n_pass;
    exp_t        q [$];
    logic [31:0] exp_dat [3];
    logic [31:0] mdl [3][256];
    bit          wr  [3][256];

    // Instance k waits 1, 0, 3 cycles respectively.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_ram_slave #(
            .ADDR_WIDTH  (8),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk_i     (clk),
            .rst_n_i   (rst_n),
            .wbs_dat_i (dat_i[g]),
            .wbs_dat_o (dat_o[g]),
            .wbs_adr_i (adr_i[g]),
            .wbs_sel_i (sel_i[g]),
            .wbs_we_i  (we_i[g]),
            .wbs_cyc_i (cyc_i[g]),
            .wbs_stb_i (stb_i[g]),
            .wbs_ack_o (ack_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%08h required=%08h (cycle %0d)", nm, act, exp, cyc_n);
    endtask

    // Issue one transfer in the current cycle. The reference: ack arrives
    // WAIT_STATES+1 cycles after the request is first present; the word is
    // addressed by byte address bits [9:2].
    task automatic xfer(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s, input bit keep);
        exp_t e;
        int   idx;
        idx      = int'(a[9:2]);
        cyc_i[k] = 1'b1;
        stb_i[k] = 1'b1;
        we_i[k]  = w;
        adr_i[k] = a;
        dat_i[k] = d;
        sel_i[k] = s;
        e.id      = k;
        e.ack_cyc = cyc_n + 1 + ws_of(k);
        e.rd      = !w;
        e.data    = mdl[k][idx];
        if (w) begin
            if (s == 2'b11) wr[k][idx] = 1'b1;
            if (s[1]) mdl[k][idx][31:16] = d[31:16];
            if (s[0]) mdl[k][idx][15:0]  = d[15:0];
        end
        q.push_back(e);
        repeat (ws_of(k) + 1) @(posedge clk);
        #1;
        if (!keep) begin
            cyc_i[k] = 1'b0;
            stb_i[k] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Start a write and drop the strobe 'drop' cycles later, before it commits.
    task automatic abort_wr(input int k, input logic [31:0] a, input logic [31:0] d, input int drop);
        cyc_i[k] = 1'b1;
        stb_i[k] = 1'b1;
        we_i[k]  = 1'b1;
        adr_i[k] = a;
        dat_i[k] = d;
        sel_i[k] = 2'b11;
        repeat (drop) @(posedge clk);
        #1;
        stb_i[k] = 1'b0;
        @(posedge clk);
        #1;
        cyc_i[k] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: match every ack against the queue, check its cycle and read
    // data, flag overdue acks and verify the data output holds otherwise.
    always @(negedge clk) begin
        int idx;
        for (int k = 0; k < 3; k++) begin
            if (ack_o[k] === 1'b1) begin
                idx = -1;
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].id == k) begin
                        idx = i;
                        break;
                    end
                end
                if (idx < 0) begin
                    chk(1'b0, "spurious_ack", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    chk(q[idx].ack_cyc == cyc_n, "ack_cycle", 32'(cyc_n), 32'(q[idx].ack_cyc));
                    if (q[idx].rd) exp_dat[k] = q[idx].data;
                    q.delete(idx);
                end
            end
            chk(dat_o[k] === exp_dat[k], "dat_o", dat_o[k], exp_dat[k]);
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].ack_cyc < cyc_n) begin
                chk(1'b0, "missing_ack", 32'(q[i].id), 32'(q[i].ack_cyc));
                q.delete(i);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k;
        int          nk;
        int          idx;
        bit          keep;
        logic [31:0] r;
        logic [31:0] a;

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_dat[i] = 32'h0;
            cyc_i[i]   = 1'b0;
            stb_i[i]   = 1'b0;
            we_i[i]    = 1'b0;
            adr_i[i]   = 32'h0;
            dat_i[i]   = 32'h0;
            sel_i[i]   = 2'b00;
            for (int j = 0; j < 256; j++) begin
                wr[i][j]  = 1'b0;
                mdl[i][j] = 32'h0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk(ack_o[i] == 1'b0, "reset_ack", 32'(ack_o[i]), 32'h0);
            chk(dat_o[i] == 32'h0, "reset_dat", dat_o[i], 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // WAIT_STATES=1: write then read back, lane merge, empty lane select.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0,        2'b11, 1'b0);
        xfer(0, 1'b1, 32'h20, 32'h11112222, 2'b11, 1'b0);
        xfer(0, 1'b1, 32'h20, 32'hAAAABBBB, 2'b10, 1'b0);
        xfer(0, 1'b0, 32'h20, 32'h0,        2'b00, 1'b0);
        xfer(0, 1'b1, 32'h20, 32'h99999999, 2'b00, 1'b0);
        xfer(0, 1'b0, 32'h20, 32'h0,        2'b00, 1'b0);

        // WAIT_STATES=0: alias through high address bits, back-to-back reads.
        xfer(1, 1'b1, 32'h000, 32'h0000CAFE, 2'b11, 1'b0);
        xfer(1, 1'b0, 32'h400, 32'h0,        2'b11, 1'b1);
        xfer(1, 1'b0, 32'h401, 32'h0,        2'b11, 1'b1);
        xfer(1, 1'b0, 32'hFFFF_FC02, 32'h0,  2'b11, 1'b0);

        // WAIT_STATES=3: aborted write leaves the word intact.
        xfer(2, 1'b1, 32'h40, 32'h55AA55AA, 2'b11, 1'b0);
        xfer(2, 1'b0, 32'h40, 32'h0,        2'b11, 1'b0);
        abort_wr(2, 32'h40, 32'h12345678, 2);
        xfer(2, 1'b0, 32'h40, 32'h0,        2'b11, 1'b0);

        // Strobe without cycle must be ignored.
        stb_i[2] = 1'b1;
        we_i[2]  = 1'b1;
        dat_i[2] = 32'h0BADF00D;
        repeat (4) @(posedge clk);
        #1;
        stb_i[2] = 1'b0;
        xfer(2, 1'b0, 32'h40, 32'h0, 2'b11, 1'b0);

        // Reset in the middle of a wait-stated write.
        cyc_i[2] = 1'b1;
        stb_i[2] = 1'b1;
        we_i[2]  = 1'b1;
        adr_i[2] = 32'h40;
        dat_i[2] = 32'h0BADF00D;
        sel_i[2] = 2'b11;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) exp_dat[i] = 32'h0;
        #1;
        chk(ack_o[2] == 1'b0, "rst_mid_wait_ack", 32'(ack_o[2]), 32'h0);
        chk(dat_o[2] == 32'h0, "rst_mid_wait_dat", dat_o[2], 32'h0);
        cyc_i[2] = 1'b0;
        stb_i[2] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        // First request right after release is sampled on the next edge.
        xfer(2, 1'b0, 32'h40, 32'h0, 2'b11, 1'b0);

        // Reset while ack is showing.
        cyc_i[0] = 1'b1;
        stb_i[0] = 1'b1;
        we_i[0]  = 1'b0;
        adr_i[0] = 32'h10;
        repeat (2) @(posedge clk);
        #1;
        chk(ack_o[0] == 1'b1, "ack_before_reset", 32'(ack_o[0]), 32'h1);
        chk(dat_o[0] == 32'hDEADBEEF, "dat_before_reset", dat_o[0], 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) exp_dat[i] = 32'h0;
        #1;
        chk(ack_o[0] == 1'b0, "rst_in_ack_ack", 32'(ack_o[0]), 32'h0);
        chk(dat_o[0] == 32'h0, "rst_in_ack_dat", dat_o[0], 32'h0);
        cyc_i[0] = 1'b0;
        stb_i[0] = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Random traffic over a small word pool with aliased addresses.
        nk = int'($urandom_range(0, 2));
        for (int it = 0; it < 200; it++) begin
            k    = nk;
            nk   = int'($urandom_range(0, 2));
            keep = (nk == k) && ($urandom_range(0, 1) == 1) && (it != 199);
            idx  = int'($urandom_range(0, 15));
            r    = $urandom();
            a    = {r[31:10], 8'(idx), r[1:0]};
            if (ws_of(k) > 0 && $urandom_range(0, 9) == 0) begin
                abort_wr(k, a, $urandom(), int'($urandom_range(1, ws_of(k))));
                if (keep) keep = 1'b0;
            end else if (wr[k][idx] && $urandom_range(0, 1) == 1) begin
                xfer(k, 1'b0, a, $urandom(), 2'(r[3:2]), keep);
            end else begin
                xfer(k, 1'b1, a, $urandom(), 2'(r[5:4]), keep);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc_i[i] = 1'b0;
            stb_i[i] = 1'b0;
        end

        repeat (10) @(posedge clk);
        #1;
        while (q.size() > 0) begin
            chk(1'b0, "unacked_at_end", 32'(q[0].id), 32'(q[0].ack_cyc));
            void'(q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
